// File: rtl/thresh_frame_buf.sv
// thresh_frame_buf: buffers one full frame, derives a threshold (frame mean or fixed),
// then streams the frame out binarized, inverted-binarized or unchanged.
module thresh_frame_buf #(
  parameter int IMG_W = 10,
  parameter int IMG_H = 10,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       mode_i,
  input  logic [PIX_W-1:0] thr_fixed_i,
  output logic [PIX_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o
);
  localparam int N     = IMG_W * IMG_H;
  localparam int SUM_W = PIX_W + $clog2(N + 1);
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
  localparam logic [AW-1:0]    LAST    = AW'(N - 1);

  typedef enum logic [1:0] {FILL, CALC, LOAD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [PIX_W-1:0] thr_q, thr_d, out_q, out_d, rd_pix, pix_f;
  logic [1:0]       fmode_q, fmode_d;
  logic             vld_q, vld_d, in_fire, out_fire;
  logic [PIX_W-1:0] mem_q [N];

  function automatic logic [PIX_W-1:0] map_pix(input logic [PIX_W-1:0] p, t, input logic [1:0] m);
    return (m == 2'b11) ? p : (((p > t) ^ (m == 2'b10)) ? PIX_MAX : '0);
  endfunction

  assign in_ready_o  = state_q == FILL;
  assign busy_o      = state_q != FILL;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = vld_q && out_ready_i;
  assign out_data_o  = out_q;
  assign out_valid_o = vld_q;
  assign out_last_o  = vld_q && (rd_q == LAST);
  assign rd_nxt      = rd_q + 1'b1;
  // LOAD prefetches pixel 0; DRAIN prefetches the successor of the pixel on the bus
  assign rd_pix      = mem_q[(state_q == LOAD) ? '0 : rd_nxt];
  assign pix_f       = map_pix(rd_pix, thr_q, fmode_q);

  always_ff @(posedge clk)
    if (in_fire) mem_q[wr_q] <= in_data_i;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= FILL;
      wr_q    <= '0;
      rd_q    <= '0;
      sum_q   <= '0;
      thr_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      fmode_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      sum_q   <= sum_d;
      thr_q   <= thr_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      fmode_q <= fmode_d;
    end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    sum_d   = sum_q;
    thr_d   = thr_q;
    out_d   = out_q;
    vld_d   = vld_q;
    fmode_d = fmode_q;
    case (state_q)
      FILL: if (in_fire) begin
        sum_d   = sum_q + SUM_W'(in_data_i);
        wr_d    = (wr_q == LAST) ? '0 : wr_q + 1'b1;
        state_d = (wr_q == LAST) ? CALC : FILL;
      end
      CALC: begin
        fmode_d = mode_i;
        thr_d   = (mode_i == 2'b01) ? thr_fixed_i : PIX_W'(sum_q / SUM_W'(N));
        state_d = LOAD;
      end
      LOAD: begin
        out_d   = pix_f;
        vld_d   = 1'b1;
        rd_d    = '0;
        state_d = DRAIN;
      end
      default: if (out_fire) begin
        if (rd_q == LAST) begin
          vld_d   = 1'b0;
          sum_d   = '0;
          wr_d    = '0;
          state_d = FILL;
        end else begin
          rd_d  = rd_nxt;
          out_d = pix_f;
        end
      end
    endcase
  end
endmodule
